// File: rtl/handshake_receiver.sv
// Receive side of the single-wire handshake lane: synchronizes the line, captures a
// 12-bit frame after the start bit and decodes ACK / GAME_LOST. Optional: HND_MAJORITY_VOTE_EN.
module handshake_receiver #(
    parameter int HEAD_BITS     = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     game_active,
    input  logic                     serial_in,
    output logic                     ack_received,
    output logic                     game_lost_received,
    output logic                     received_seqNum_h,
    output logic                     frame_error,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     rx_busy
);

    localparam int CNT_W = $clog2(HEAD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(HEAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DECODE = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sin;
    logic [HEAD_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   pad_ok;
    logic                   seq_ok;
    logic                   seq_bit;
    logic                   is_ack;
    logic                   is_lost;
    logic                   frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign sin = sync_q[SYNC_STAGES-1];

`ifdef HND_MAJORITY_VOTE_EN
    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [2:0] seq_ones;
    logic [2:0] type_ones;

    // Each field tolerates one flipped bit; a 2-2 split is ambiguous and rejected.
    always_comb begin
        seq_ones  = popcnt4(shift_q[7:4]);
        type_ones = popcnt4(shift_q[3:0]);
        pad_ok    = (shift_q[HEAD_BITS-1:8] == '0);
        seq_ok    = (seq_ones != 3'd2);
        seq_bit   = (seq_ones >= 3'd3);
        is_ack    = (type_ones >= 3'd3);
        is_lost   = (type_ones <= 3'd1);
        frame_ok  = pad_ok && seq_ok && (is_ack || is_lost);
    end
`else
    always_comb begin
        pad_ok   = (shift_q[HEAD_BITS-1:8] == '0);
        seq_ok   = (shift_q[7:4] == 4'b0000) || (shift_q[7:4] == 4'b1111);
        seq_bit  = shift_q[4];
        is_ack   = (shift_q[3:0] == 4'b1111);
        is_lost  = (shift_q[3:0] == 4'b0000);
        frame_ok = pad_ok && seq_ok && (is_ack || is_lost);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            shift_q            <= '0;
            bit_cnt            <= '0;
            ack_received       <= 1'b0;
            game_lost_received <= 1'b0;
            frame_error        <= 1'b0;
            received_seqNum_h  <= 1'b0;
            err_cnt            <= '0;
        end else begin
            ack_received       <= 1'b0;
            game_lost_received <= 1'b0;
            frame_error        <= 1'b0;
            case (state)
                IDLE: begin
                    if (sin && game_active) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (!game_active) begin
                        state   <= GAP;
                        shift_q <= '0;
                        bit_cnt <= '0;
                    end else begin
                        shift_q <= {shift_q[HEAD_BITS-2:0], sin};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    state <= GAP;
                    if (!game_active) begin
                        shift_q <= '0;
                    end else if (frame_ok) begin
                        ack_received       <= is_ack;
                        game_lost_received <= !is_ack;
                        received_seqNum_h  <= seq_bit;
                    end else begin
                        frame_error <= 1'b1;
                        if (err_cnt != {ERR_CNT_WIDTH{1'b1}}) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    // A line stuck high must not re-trigger; require a low cycle first.
                    if (!sin) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state == RECV) || (state == DECODE);

endmodule
